// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side handshake signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface mem_arbiter_if;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [63:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [63:0] lsu_req_addr;
  logic        lsu_req_wen;
  logic [63:0] lsu_req_wdata;
  logic [7:0]  lsu_req_wmask;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;

  logic [63:0] resp_data;
  logic        resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    input  lsu_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output ifu_req_ready, ifu_resp_valid,
    output lsu_req_ready, lsu_resp_valid,
    output resp_data, resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
    output lsu_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  ifu_req_ready, ifu_resp_valid,
    input  lsu_req_ready, lsu_resp_valid,
    input  resp_data, resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (IFU/LSU) round-robin arbiter onto a single memory port,
// one transaction outstanding, with a response timeout in WAIT.
//
//  state   | meaning
//  --------+---------------------------------------------------------
//  S_IDLE  | arbitrate; granted requester sees req_ready
//  S_ISSUE | mem_req_valid high with registered fields until accepted
//  S_WAIT  | wait for mem_resp_valid or timeout down-counter expiry
//  S_RESP  | owner's resp_valid high until owner's resp_ready
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst_n,
  mem_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  // Loaded on entry to WAIT so terminal count lands after TIMEOUT WAIT cycles.
  localparam logic [15:0] TC_LOAD = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic        last_grant;
  logic        owner;
  logic [15:0] tmr_cnt;
  logic [63:0] addr_q;
  logic        wen_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic grant_lsu;
  logic grant_ifu;
  logic ifu_ready;
  logic lsu_ready;
  logic resp_take;

  always_comb begin
    grant_lsu = bus.lsu_req_valid && (!bus.ifu_req_valid || (last_grant == OWN_IFU));
    grant_ifu = bus.ifu_req_valid && !grant_lsu;
    ifu_ready = rst_n && (state == S_IDLE) && grant_ifu;
    lsu_ready = rst_n && (state == S_IDLE) && grant_lsu;
    resp_take = (owner == OWN_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= OWN_IFU;
      owner      <= OWN_IFU;
      tmr_cnt    <= 16'd0;
      addr_q     <= 64'd0;
      wen_q      <= 1'b0;
      wdata_q    <= 64'd0;
      wmask_q    <= 8'd0;
      rdata_q    <= 64'd0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (lsu_ready) begin
            owner      <= OWN_LSU;
            last_grant <= OWN_LSU;
            addr_q     <= bus.lsu_req_addr;
            wen_q      <= bus.lsu_req_wen;
            wdata_q    <= bus.lsu_req_wdata;
            wmask_q    <= bus.lsu_req_wmask;
            state      <= S_ISSUE;
          end else if (ifu_ready) begin
            owner      <= OWN_IFU;
            last_grant <= OWN_IFU;
            addr_q     <= bus.ifu_req_addr;
            wen_q      <= 1'b0;
            wdata_q    <= 64'd0;
            wmask_q    <= 8'd0;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (bus.mem_req_ready) begin
            tmr_cnt <= TC_LOAD;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_resp_valid) begin
            rdata_q <= bus.mem_resp_data;
            err_q   <= 1'b0;
            state   <= S_RESP;
          end else if (tmr_cnt == 16'd0) begin
            rdata_q <= 64'd0;
            err_q   <= 1'b1;
            state   <= S_RESP;
          end else begin
            tmr_cnt <= tmr_cnt - 16'd1;
          end
        end
        S_RESP: begin
          if (resp_take) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ifu_req_ready  = ifu_ready;
  assign bus.lsu_req_ready  = lsu_ready;
  assign bus.ifu_resp_valid = (state == S_RESP) && (owner == OWN_IFU);
  assign bus.lsu_resp_valid = (state == S_RESP) && (owner == OWN_LSU);
  assign bus.resp_data      = rdata_q;
  assign bus.resp_err       = err_q;
  assign bus.mem_req_valid  = (state == S_ISSUE);
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;

endmodule
